// File: rtl/pred_pkg.sv
// Shared types, counter encodings and PC field helpers for the next-PC predictor.
// PRED_RAS_EN adds the is_ret bit to each BTB entry.
package pred_pkg;

   localparam int unsigned PKG_ADDR_W = 32;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   typedef logic [PKG_ADDR_W-1:0] addr_t;

   // Tag is kept right-justified at full width so one entry type serves any BTB size
   typedef struct packed {
      logic  valid;
      addr_t tag;
      addr_t target;
`ifdef PRED_RAS_EN
      logic  is_ret;
`endif
   } btb_entry_t;

   function automatic addr_t pc_bidx(input addr_t pc, input int unsigned idx_w);
      return (pc >> 2) & ((addr_t'(1) << idx_w) - addr_t'(1));
   endfunction

   function automatic addr_t pc_hidx(input addr_t pc, input int unsigned idx_w);
      return (pc >> 2) & ((addr_t'(1) << idx_w) - addr_t'(1));
   endfunction

   function automatic addr_t pc_tag(input addr_t pc, input int unsigned idx_w);
      return pc >> (idx_w + 2);
   endfunction

endpackage

// File: rtl/pred_ras.sv
// Circular return address stack; a push on a full stack overwrites the oldest entry.
module pred_ras #(
   parameter int unsigned W     = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] push_data,
   output logic [W-1:0] top,
   output logic         empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] ptr, ptr_pop, ptr_nxt;
   logic [CNT_W-1:0] cnt, cnt_pop, cnt_nxt;

   // Pop is applied before push so a combined call/return replaces the top
   always_comb begin
      ptr_pop = ptr;
      cnt_pop = cnt;
      if (pop && (cnt != '0)) begin
         ptr_pop = ptr - PTR_W'(1);
         cnt_pop = cnt - CNT_W'(1);
      end
      ptr_nxt = ptr_pop;
      cnt_nxt = cnt_pop;
      if (push) begin
         ptr_nxt = ptr_pop + PTR_W'(1);
         if (cnt_pop != CNT_W'(DEPTH)) begin
            cnt_nxt = cnt_pop + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= '0;
         cnt <= '0;
         mem <= '{default: '0};
      end else begin
         ptr <= ptr_nxt;
         cnt <= cnt_nxt;
         if (push) begin
            mem[ptr_pop] <= push_data;
         end
      end
   end

   assign top   = mem[ptr - PTR_W'(1)];
   assign empty = (cnt == '0);

endmodule

// File: rtl/pc_predictor.sv
// Fetch-stage next-PC generator: direct-mapped BTB plus 2-bit counter table, with ALU redirect.
// Optional return address stack for jr $ra is enabled by defining PRED_RAS_EN.
module pc_predictor
   import pred_pkg::*;
#(
   parameter int unsigned       ADDR_W      = 32,
   parameter int unsigned       BTB_ENTRIES = 16,
   parameter int unsigned       BHT_ENTRIES = 64,
   parameter int unsigned       RAS_DEPTH   = 4,
   parameter logic [ADDR_W-1:0] INIT_PC     = ADDR_W'(32'hBFC0_0000)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_stall,
   output logic [ADDR_W-1:0] npc,
   output logic              pred_taken,
   output logic [ADDR_W-1:0] pred_target,
   input  logic              br_late,
   input  logic [ADDR_W-1:0] br_late_target,
   output logic              br_late_done,
   input  logic              upd_valid,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic              upd_taken,
   input  logic [ADDR_W-1:0] upd_target,
   input  logic              upd_is_call,
   input  logic              upd_is_ret
);

   localparam int unsigned BIDX_W = $clog2(BTB_ENTRIES);
   localparam int unsigned HIDX_W = $clog2(BHT_ENTRIES);

   if ((ADDR_W > PKG_ADDR_W) || (BTB_ENTRIES < 2) || ((BTB_ENTRIES & (BTB_ENTRIES - 1)) != 0) ||
       (BHT_ENTRIES < 2) || ((BHT_ENTRIES & (BHT_ENTRIES - 1)) != 0) ||
       (RAS_DEPTH < 2) || ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_param_check
      $error("pc_predictor: unsupported parameter set");
   end

   logic [ADDR_W-1:0] pc, pc_nxt;
   btb_entry_t        btb [BTB_ENTRIES];
   logic [1:0]        bht [BHT_ENTRIES];
   logic [BIDX_W-1:0] bidx, upd_bidx;
   logic [HIDX_W-1:0] hidx, upd_hidx;
   btb_entry_t        rd_e, wr_e;
   logic              btb_hit;
   logic [1:0]        ctr_cur, ctr_nxt;

`ifdef PRED_RAS_EN
   logic              ras_empty;
   logic [ADDR_W-1:0] ras_top;

   pred_ras #(
      .W     (ADDR_W),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (upd_valid && upd_is_call),
      .pop       (upd_valid && upd_is_ret),
      .push_data (upd_pc + ADDR_W'(8)),
      .top       (ras_top),
      .empty     (ras_empty)
   );
`else
   logic unused_ras;
   assign unused_ras = ^{upd_is_call, upd_is_ret};
`endif

   assign npc      = pc;
   assign bidx     = BIDX_W'(pc_bidx(PKG_ADDR_W'(pc), BIDX_W));
   assign hidx     = HIDX_W'(pc_hidx(PKG_ADDR_W'(pc), HIDX_W));
   assign upd_bidx = BIDX_W'(pc_bidx(PKG_ADDR_W'(upd_pc), BIDX_W));
   assign upd_hidx = HIDX_W'(pc_hidx(PKG_ADDR_W'(upd_pc), HIDX_W));

   // Lookup on the current pc and next-pc selection
   always_comb begin
      rd_e        = btb[bidx];
      btb_hit     = rd_e.valid && (rd_e.tag == pc_tag(PKG_ADDR_W'(pc), BIDX_W));
      pred_taken  = btb_hit && (bht[hidx] >= WT);
      pred_target = btb_hit ? ADDR_W'(rd_e.target) : '0;
`ifdef PRED_RAS_EN
      if (btb_hit && rd_e.is_ret && !ras_empty) begin
         pred_taken  = 1'b1;
         pred_target = ras_top;
      end
`endif
      pc_nxt = pc + ADDR_W'(4);
      if (br_late) begin
         pc_nxt = br_late_target;
      end else if (fetch_stall) begin
         pc_nxt = pc;
      end else if (pred_taken) begin
         pc_nxt = pred_target;
      end
   end

   // Training values from the resolved branch
   always_comb begin
      wr_e        = '0;
      wr_e.valid  = 1'b1;
      wr_e.tag    = pc_tag(PKG_ADDR_W'(upd_pc), BIDX_W);
      wr_e.target = PKG_ADDR_W'(upd_target);
`ifdef PRED_RAS_EN
      wr_e.is_ret = upd_is_ret;
`endif
      ctr_cur = bht[upd_hidx];
      ctr_nxt = ctr_cur;
      if (upd_taken) begin
         if (ctr_cur != ST) ctr_nxt = ctr_cur + 2'd1;
      end else begin
         if (ctr_cur != SNT) ctr_nxt = ctr_cur - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc           <= INIT_PC;
         br_late_done <= 1'b0;
         btb          <= '{default: '0};
         bht          <= '{default: WNT};
      end else begin
         pc           <= pc_nxt;
         br_late_done <= br_late;
         if (upd_valid) begin
            bht[upd_hidx] <= ctr_nxt;
            if (upd_taken) begin
               btb[upd_bidx] <= wr_e;
            end
         end
      end
   end

endmodule

// File: tb/tb_pc_predictor.sv
// Self-checking bench for pc_predictor: directed scenarios plus randomized traffic against a table model.
module tb_pc_predictor;

   localparam int          NB   = 16;
   localparam int          NH   = 64;
   localparam int          RD   = 4;
   localparam logic [31:0] INIT = 32'hBFC0_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_stall;
   logic [31:0] npc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        br_late;
   logic [31:0] br_late_target;
   logic        br_late_done;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_is_call;
   logic        upd_is_ret;

   int checks = 0;
   int errors = 0;

   // Reference state
   bit          m_v   [NB];
   logic [31:0] m_tg  [NB];
   logic [31:0] m_tgt [NB];
   bit          m_ret [NB];
   int          m_ctr [NH];
   logic [31:0] m_ras [$];
   logic [31:0] m_pc;
   bit          m_done;

   always #5 clk = ~clk;

   pc_predictor dut (
      .clk            (clk),
      .rst            (rst),
      .fetch_stall    (fetch_stall),
      .npc            (npc),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .br_late        (br_late),
      .br_late_target (br_late_target),
      .br_late_done   (br_late_done),
      .upd_valid      (upd_valid),
      .upd_pc         (upd_pc),
      .upd_taken      (upd_taken),
      .upd_target     (upd_target),
      .upd_is_call    (upd_is_call),
      .upd_is_ret     (upd_is_ret)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model_pred(input logic [31:0] pc, output bit tk, output logic [31:0] tg);
      int  bi  = int'((pc / 4) % NB);
      int  hi  = int'((pc / 4) % NH);
      bit  hit = m_v[bi] && (m_tg[bi] == pc / (4 * NB));
      tk = hit && (m_ctr[hi] >= 2);
      tg = hit ? m_tgt[bi] : 32'h0;
`ifdef PRED_RAS_EN
      if (hit && m_ret[bi] && (m_ras.size() > 0)) begin
         tk = 1'b1;
         tg = m_ras[$];
      end
`endif
   endfunction

   task automatic model_reset();
      m_pc   = INIT;
      m_done = 1'b0;
      for (int i = 0; i < NB; i++) begin
         m_v[i] = 1'b0; m_tg[i] = '0; m_tgt[i] = '0; m_ret[i] = 1'b0;
      end
      for (int i = 0; i < NH; i++) m_ctr[i] = 1;
      m_ras.delete();
   endtask

   task automatic model_step();
      bit          tk;
      logic [31:0] tg;
      int          bi, hi;
      logic [31:0] ra;
      if (!rst) begin
         model_reset();
         return;
      end
      model_pred(m_pc, tk, tg);
      m_pc   = br_late ? br_late_target : fetch_stall ? m_pc : tk ? tg : m_pc + 32'd4;
      m_done = br_late;
      if (upd_valid) begin
         bi = int'((upd_pc / 4) % NB);
         hi = int'((upd_pc / 4) % NH);
         m_ctr[hi] = upd_taken ? ((m_ctr[hi] == 3) ? 3 : m_ctr[hi] + 1)
                               : ((m_ctr[hi] == 0) ? 0 : m_ctr[hi] - 1);
         if (upd_taken) begin
            m_v[bi]   = 1'b1;
            m_tg[bi]  = upd_pc / (4 * NB);
            m_tgt[bi] = upd_target;
            m_ret[bi] = upd_is_ret;
         end
`ifdef PRED_RAS_EN
         if (upd_is_ret && (m_ras.size() > 0)) void'(m_ras.pop_back());
         if (upd_is_call) begin
            ra = upd_pc + 32'd8;
            m_ras.push_back(ra);
            if (m_ras.size() > RD) void'(m_ras.pop_front());
         end
`else
         ra = '0;
`endif
      end
   endtask

   task automatic check_outputs();
      bit          tk;
      logic [31:0] tg;
      model_pred(m_pc, tk, tg);
      chk("npc", npc, m_pc);
      chk("pred_taken", 32'(pred_taken), 32'(tk));
      chk("pred_target", pred_target, tg);
      chk("br_late_done", 32'(br_late_done), 32'(m_done));
   endtask

   // One clock: model follows the edge, outputs compared on the falling edge
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic clear_in();
      fetch_stall = 0; br_late = 0; br_late_target = '0; upd_valid = 0;
      upd_pc = '0; upd_taken = 0; upd_target = '0; upd_is_call = 0; upd_is_ret = 0;
   endtask

   task automatic upd(input logic [31:0] pc, input bit tk, input logic [31:0] tg,
                      input bit call, input bit ret);
      upd_valid = 1; upd_pc = pc; upd_taken = tk; upd_target = tg;
      upd_is_call = call; upd_is_ret = ret;
   endtask

   task automatic redirect(input logic [31:0] tg);
      clear_in();
      br_late = 1; br_late_target = tg;
      cycle();
      br_late = 0;
   endtask

   initial begin
      rst = 1'b0;
      clear_in();
      model_reset();
      repeat (2) cycle();
      chk("reset_npc", npc, INIT);
      chk("reset_pred_taken", 32'(pred_taken), 32'h0);
      chk("reset_done", 32'(br_late_done), 32'h0);
      rst = 1'b1;
      chk("release_npc0", npc, 32'hBFC0_0000);
      cycle(); chk("release_npc1", npc, 32'hBFC0_0004);
      cycle(); chk("release_npc2", npc, 32'hBFC0_0008);

      // Training to taken, then back to not-taken
      upd(32'h100, 1, 32'h80, 0, 0); cycle(); cycle();
      redirect(32'h100);
      chk("train_npc", npc, 32'h100);
      chk("train_done", 32'(br_late_done), 32'h1);
      chk("train_taken", 32'(pred_taken), 32'h1);
      chk("train_target", pred_target, 32'h80);
      cycle(); chk("train_follow", npc, 32'h80);
      chk("train_done_clear", 32'(br_late_done), 32'h0);
      upd(32'h100, 0, 32'h0, 0, 0); cycle(); cycle();
      redirect(32'h100);
      chk("untrain_taken", 32'(pred_taken), 32'h0);
      chk("untrain_target", pred_target, 32'h80);
      cycle(); chk("untrain_fall", npc, 32'h104);

      // Redirect beats stall and prediction
      upd(32'h100, 1, 32'h80, 0, 0); cycle(); cycle();
      redirect(32'h100);
      chk("prio_taken", 32'(pred_taken), 32'h1);
      br_late = 1; br_late_target = 32'h400; fetch_stall = 1;
      cycle(); chk("prio_npc", npc, 32'h400); chk("prio_done", 32'(br_late_done), 32'h1);
      br_late = 0;
      cycle(); chk("stall_hold", npc, 32'h400); chk("prio_done_once", 32'(br_late_done), 32'h0);
      fetch_stall = 0;
      cycle(); chk("stall_release", npc, 32'h404);
      br_late = 1; br_late_target = 32'h600; cycle();
      br_late_target = 32'h700; cycle();
      chk("b2b_npc", npc, 32'h700); chk("b2b_done", 32'(br_late_done), 32'h1);
      br_late = 0; cycle(); chk("b2b_done_clear", 32'(br_late_done), 32'h0);

      // Saturation and same-cycle update/lookup
      for (int k = 0; k < 5; k++) begin upd(32'h100, 1, 32'h80, 0, 0); cycle(); end
      upd(32'h100, 0, 32'h0, 0, 0); cycle();
      redirect(32'h100);
      chk("sat_taken", 32'(pred_taken), 32'h1);
      upd(32'h100, 0, 32'h0, 0, 0); cycle();
      chk("same_cycle_old", npc, 32'h80);
      redirect(32'h100);
      chk("same_cycle_new", 32'(pred_taken), 32'h0);

      // Aliasing: 0x140 shares the BTB slot of 0x100
      upd(32'h140, 1, 32'h200, 0, 0); cycle();
      redirect(32'h100);
      chk("alias_miss_taken", 32'(pred_taken), 32'h0);
      chk("alias_miss_target", pred_target, 32'h0);
      cycle(); chk("alias_fall", npc, 32'h104);
      redirect(32'h140);
      chk("alias_hit_target", pred_target, 32'h200);

      redirect(32'hFFFF_FFFC);
      cycle(); chk("wrap_npc", npc, 32'h0);

`ifdef PRED_RAS_EN
      upd(32'h504, 1, 32'h111, 0, 1); cycle();
      upd(32'h300, 0, 32'h0, 1, 0); cycle();
      redirect(32'h504);
      chk("ras_target", pred_target, 32'h308);
      chk("ras_taken", 32'(pred_taken), 32'h1);
      for (int k = 0; k < 5; k++) begin upd(32'h1000 + 32'(16 * k), 0, 32'h0, 1, 0); cycle(); end
      for (int k = 0; k < 3; k++) begin upd(32'h504, 1, 32'h111, 0, 1); cycle(); end
      redirect(32'h504);
      chk("ras_after_pops", pred_target, 32'h1018);
      upd(32'h504, 1, 32'h111, 0, 1); cycle();
      redirect(32'h504);
      chk("ras_oldest_lost", pred_target, 32'h111);
      upd(32'h504, 1, 32'h111, 0, 1); cycle();
      redirect(32'h504);
      chk("ras_pop_empty", pred_target, 32'h111);
`endif

      // Randomized traffic in a small address window so entries hit and alias
      for (int n = 0; n < 3000; n++) begin
         clear_in();
         rst            = (n >= 1500 && n < 1502) ? 1'b0 : 1'b1;
         br_late        = ($urandom_range(0, 9) == 0);
         br_late_target = 32'h100 + 32'(4 * $urandom_range(0, 127));
         fetch_stall    = ($urandom_range(0, 4) == 0);
         upd_valid      = $urandom_range(0, 1) == 1;
         upd_pc         = 32'h100 + 32'(4 * $urandom_range(0, 127));
         upd_taken      = ($urandom_range(0, 9) < 6);
         upd_target     = 32'h100 + 32'(4 * $urandom_range(0, 127));
         upd_is_call    = ($urandom_range(0, 9) == 0);
         upd_is_ret     = ($urandom_range(0, 9) == 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
